appr_err_stats: RTL and testbench

APPR_ERR_STATS -- requirements
Module: appr_err_stats

---
 rtl/appr_err_stats.sv | 190 +++++++++++++++++++
 tb/tb_appr_err_stats.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/appr_err_stats.sv
// Error-statistics collector for an approximate adder.
// Each accepted sample's error against the exact sum goes through a two-stage
// pipeline: stage 1 registers the error and its magnitude, stage 2 folds them
// into the running statistics. A run is bounded by a sample target that is
// latched when the run starts.
module appr_err_stats #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_target,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     appr_s,
  input  logic             appr_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] nz_cnt,
  output logic [63:0]      err_sum,
  output logic [95:0]      err_sq_sum,
  output logic [W:0]       max_abs_err
);

  // Signed error width: the exact sum needs W+1 bits, plus one sign bit.
  localparam int unsigned EW  = W + 2;
  // Width of |e|*|e|, with |e| held in W+1 bits.
  localparam int unsigned SqW = 2 * (W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] acc_cnt_q;

  logic             s1_valid_q;
  logic [EW-1:0]    s1_err_q;
  logic [W:0]       s1_abs_q;

  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] nz_cnt_q;
  logic [63:0]      err_sum_q;
  logic [95:0]      err_sq_sum_q;
  logic [W:0]       max_abs_q;

  logic             accept;
  logic             last_accept;
  logic             start_accept;

  logic [EW-1:0]    appr_ext;
  logic [EW-1:0]    exact_ext;
  logic [EW-1:0]    err_raw;
  logic [W:0]       err_abs;
  logic [SqW-1:0]   err_sq;
  logic [63:0]      err_sext;

  // Handshake and run-control decode.
  always_comb begin
    accept       = in_valid && in_ready;
    last_accept  = accept && ((acc_cnt_q + CNT_W'(1)) == target_q);
    start_accept = start && ((state_q == StIdle) || (state_q == StDone));
  end

  // Stage-1 combinational error: both operands zero-extended to EW bits, then subtracted.
  always_comb begin
    appr_ext  = {1'b0, appr_cout, appr_s};
    exact_ext = {2'b00, a} + {2'b00, b};
    err_raw   = appr_ext - exact_ext;
    // Magnitude never exceeds 2^(W+1)-1, so W+1 bits are enough.
    err_abs   = err_raw[EW-1] ? (W+1)'(EW'(0) - err_raw) : err_raw[W:0];
  end

  // Stage-2 combinational terms derived from the stage-1 registers.
  always_comb begin
    err_sq   = SqW'(s1_abs_q) * SqW'(s1_abs_q);
    err_sext = {{(64 - EW){s1_err_q[EW-1]}}, s1_err_q};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (n_target == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_accept) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Stage 2 consumes the final sample on the edge that empties stage 1.
        if (!s1_valid_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == StRun) && (acc_cnt_q < target_q);
    busy     = (state_q == StRun) || (state_q == StDrain);
    done     = (state_q == StDone);
  end

  // Run bookkeeping: latched target and count of accepted samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q  <= '0;
      acc_cnt_q <= '0;
    end else if (start_accept) begin
      target_q  <= n_target;
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  // Stage-1 pipeline register: error and magnitude of the accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      s1_abs_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_err_q <= err_raw;
        s1_abs_q <= err_abs;
      end
    end
  end

  // Stage-2 accumulators; all wrap modulo their width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      nz_cnt_q     <= '0;
      err_sum_q    <= '0;
      err_sq_sum_q <= '0;
      max_abs_q    <= '0;
    end else if (start_accept) begin
      sample_cnt_q <= '0;
      nz_cnt_q     <= '0;
      err_sum_q    <= '0;
      err_sq_sum_q <= '0;
      max_abs_q    <= '0;
    end else if (s1_valid_q) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (s1_err_q != '0) begin
        nz_cnt_q <= nz_cnt_q + CNT_W'(1);
      end
      err_sum_q    <= err_sum_q + err_sext;
      err_sq_sum_q <= err_sq_sum_q + {{(96 - SqW){1'b0}}, err_sq};
      if (s1_abs_q > max_abs_q) begin
        max_abs_q <= s1_abs_q;
      end
    end
  end

  assign sample_cnt  = sample_cnt_q;
  assign nz_cnt      = nz_cnt_q;
  assign err_sum     = err_sum_q;
  assign err_sq_sum  = err_sq_sum_q;
  assign max_abs_err = max_abs_q;

endmodule

// File: tb/tb_appr_err_stats.sv
// Self-checking bench for appr_err_stats (W=32, CNT_W=32).
module tb_appr_err_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] n_target = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] appr_s = '0;
  logic        appr_cout = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sample_cnt;
  logic [31:0] nz_cnt;
  logic [63:0] err_sum;
  logic [95:0] err_sq_sum;
  logic [32:0] max_abs_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qs[$];
  logic        qc[$];

  appr_err_stats #(.W(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_target   (n_target),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .appr_s     (appr_s),
    .appr_cout  (appr_cout),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .nz_cnt     (nz_cnt),
    .err_sum    (err_sum),
    .err_sq_sum (err_sq_sum),
    .max_abs_err(max_abs_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;
    logic [63:0] esum;
    logic [95:0] esq;
    logic [32:0] emax;
    logic [31:0] enz;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    start    = 1'b1;
    n_target = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qs.delete(); qc.delete();
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] s,
                      input logic c);
    qa.push_back(x); qb.push_back(y); qs.push_back(s); qc.push_back(c);
  endtask

  // Present queued samples, optionally with random in_valid gaps; returns after
  // the edge that accepts the last one.
  task automatic feed(input bit gaps);
    int idx = 0;
    int budget = 0;
    while (idx < qa.size() && budget < 500) begin
      in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a         = qa[idx];
      b         = qb[idx];
      appr_s    = qs[idx];
      appr_cout = qc[idx];
      if (in_valid && in_ready) idx++;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    chk("feed_accepted", 96'(idx), 96'(qa.size()));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("wait_done", 96'(done), 96'(1));
  endtask

  function automatic longint err_of(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] s, input logic c);
    longint ex;
    longint ap;
    ex = longint'({32'b0, x}) + longint'({32'b0, y});
    ap = longint'({31'b0, c, s});
    return ap - ex;
  endfunction

  // Reference statistics computed directly from the queued samples.
  task automatic check_model(input string tag);
    logic [63:0] s = '0;
    logic [95:0] q = '0;
    logic [32:0] m = '0;
    int          nz = 0;
    longint      e;
    logic [63:0] ab;
    for (int i = 0; i < qa.size(); i++) begin
      e  = err_of(qa[i], qb[i], qs[i], qc[i]);
      ab = (e < 0) ? 64'(-e) : 64'(e);
      s  = s + 64'(e);
      q  = q + 96'(ab) * 96'(ab);
      if (ab[32:0] > m) m = ab[32:0];
      if (e != 0) nz++;
    end
    chk({tag, "_sample_cnt"}, 96'(sample_cnt), 96'(qa.size()));
    chk({tag, "_nz_cnt"}, 96'(nz_cnt), 96'(nz));
    chk({tag, "_err_sum"}, 96'(err_sum), 96'(s));
    chk({tag, "_err_sq_sum"}, err_sq_sum, q);
    chk({tag, "_max_abs"}, 96'(max_abs_err), 96'(m));
  endtask

  initial begin
    vec_t   vt[7];
    bit     pat[5];
    int     acc;
    int     n;
    logic [32:0] t;
    int     delta;

    vt[0] = '{32'd5, 32'd7, 32'd12, 1'b0, 64'd0, 96'd0, 33'd0, 32'd0};
    vt[1] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 64'hFFFF_FFFF_0000_0000,
              96'h1_0000_0000_0000_0000, 33'h1_0000_0000, 32'd1};
    vt[2] = '{32'd0, 32'd0, 32'd0, 1'b1, 64'h1_0000_0000,
              96'h1_0000_0000_0000_0000, 33'h1_0000_0000, 32'd1};
    vt[3] = '{32'd100, 32'd50, 32'd147, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 96'd9, 33'd3, 32'd1};
    vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 64'd0, 96'd0, 33'd0, 32'd0};
    vt[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 64'h1_FFFF_FFFF,
              96'h3_FFFF_FFFC_0000_0001, 33'h1_FFFF_FFFF, 32'd1};
    vt[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 64'hFFFF_FFFE_0000_0002,
              96'h3_FFFF_FFF8_0000_0004, 33'h1_FFFF_FFFE, 32'd1};

    // Reset state.
    tick(); tick(); tick();
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_sample_cnt", 96'(sample_cnt), 96'(0));
    chk("rst_err_sq_sum", err_sq_sum, 96'd0);

    // First start on the very edge rst_n is released; zero target goes straight to done.
    rst_n = 1'b1;
    do_start(32'd0);
    chk("zero_target_done", 96'(done), 96'(1));
    chk("zero_target_busy", 96'(busy), 96'(0));
    chk("zero_target_cnt", 96'(sample_cnt), 96'(0));

    // Single-sample vectors with latency check: done appears 3 edges after acceptance.
    for (int i = 0; i < 7; i++) begin
      do_start(32'd1);
      chk("vec_busy", 96'(busy), 96'(1));
      clear_q();
      push(vt[i].a, vt[i].b, vt[i].s, vt[i].c);
      feed(1'b0);
      chk("vec_done_t1", 96'(done), 96'(0));
      tick();
      chk("vec_done_t2", 96'(done), 96'(0));
      tick();
      chk("vec_done_t3", 96'(done), 96'(1));
      chk("vec_sample_cnt", 96'(sample_cnt), 96'(1));
      chk("vec_nz_cnt", 96'(nz_cnt), 96'(vt[i].enz));
      chk("vec_err_sum", 96'(err_sum), 96'(vt[i].esum));
      chk("vec_err_sq_sum", err_sq_sum, vt[i].esq);
      chk("vec_max_abs", 96'(max_abs_err), 96'(vt[i].emax));
    end

    // Mixed-sign pair.
    do_start(32'd2);
    clear_q();
    push(32'd10, 32'd0, 32'd13, 1'b0);
    push(32'd10, 32'd0, 32'd8, 1'b0);
    feed(1'b0);
    wait_done();
    chk("mixed_err_sum", 96'(err_sum), 96'd1);
    chk("mixed_err_sq_sum", err_sq_sum, 96'd13);
    chk("mixed_max_abs", 96'(max_abs_err), 96'd3);
    chk("mixed_nz_cnt", 96'(nz_cnt), 96'd2);
    tick(); tick();
    chk("done_hold_err_sum", 96'(err_sum), 96'd1);
    chk("done_hold_done", 96'(done), 96'(1));

    // Handshake: valid pattern 1,0,1,1,1 with target 3; fifth sample must be ignored.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_start(32'd3);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid  = pat[i];
      a         = 32'(i);
      b         = 32'd0;
      appr_s    = (i == 4) ? 32'd999 : 32'(i);
      appr_cout = 1'b0;
      if (i == 4) chk("hs_ready_after_third", 96'(in_ready), 96'(0));
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("hs_accepted", 96'(acc), 96'd3);
    wait_done();
    chk("hs_sample_cnt", 96'(sample_cnt), 96'd3);
    chk("hs_nz_cnt", 96'(nz_cnt), 96'd0);

    // Start during RUN is ignored.
    do_start(32'd4);
    clear_q();
    push(32'd1, 32'd2, 32'd4, 1'b0);
    push(32'd3, 32'd3, 32'd6, 1'b0);
    feed(1'b0);
    do_start(32'd9);
    chk("ignored_start_cnt", 96'(sample_cnt), 96'd2);
    chk("ignored_start_busy", 96'(busy), 96'(1));
    clear_q();
    push(32'd7, 32'd0, 32'd7, 1'b0);
    push(32'd8, 32'd0, 32'd5, 1'b0);
    feed(1'b0);
    chk("run4_ready_low", 96'(in_ready), 96'(0));
    wait_done();
    chk("run4_sample_cnt", 96'(sample_cnt), 96'd4);
    chk("run4_nz_cnt", 96'(nz_cnt), 96'd2);

    // Reset mid-run with a sample still in flight.
    do_start(32'd4);
    clear_q();
    push(32'd1, 32'd1, 32'd9, 1'b0);
    push(32'd2, 32'd2, 32'd0, 1'b1);
    feed(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_done", 96'(done), 96'(0));
    chk("midrst_sample_cnt", 96'(sample_cnt), 96'(0));
    tick(); tick(); tick();
    chk("midrst_no_partial_cnt", 96'(sample_cnt), 96'(0));
    chk("midrst_no_partial_sum", 96'(err_sum), 96'(0));
    chk("midrst_no_partial_max", 96'(max_abs_err), 96'(0));
    do_start(32'd1);
    clear_q();
    push(32'd100, 32'd50, 32'd147, 1'b0);
    feed(1'b0);
    wait_done();
    check_model("post_rst");

    // Randomized runs against the reference model.
    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 8);
      do_start(32'(n));
      clear_q();
      for (int i = 0; i < n; i++) begin
        a = $urandom();
        b = $urandom();
        if ($urandom_range(0, 2) == 0) begin
          push(a, b, $urandom(), 1'($urandom_range(0, 1)));
        end else begin
          delta = $urandom_range(0, 8) - 4;
          t = {1'b0, a} + {1'b0, b} + 33'(delta);
          push(a, b, t[31:0], t[32]);
        end
      end
      feed(1'b1);
      wait_done();
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
